// File: rtl/uart_param.sv
// uart_param: 16x-oversampling UART with configurable framing and an RX FIFO
// whose entries carry their own error flags. Define UART_PARAM_PARITY_EN to build parity.
module uart_param #(
  parameter int unsigned XTAL         = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned DATABITS     = 8,
  parameter int unsigned STOPBITS     = 1,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned RXFIFO_DEPTH = 4
) (
  input  logic                SYSCLK,
  input  logic                RESET,
  input  logic [DATABITS-1:0] txData,
  input  logic                txStb,
  output logic                txRdy,
  output logic                tx,
  input  logic                rx,
  output logic [DATABITS-1:0] rxData,
  output logic                rxRdy,
  input  logic                rxAck,
  output logic                rxFrameErr,
  output logic                rxParityErr,
  output logic                rxOverrun
);

  localparam int unsigned DIV      = XTAL / (BAUD * 16);
  localparam int unsigned DIVW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SUBW     = 5;
  localparam int unsigned BITW     = 4;
  localparam int unsigned PTRW     = $clog2(RXFIFO_DEPTH);
  localparam int unsigned CNTW     = PTRW + 1;
  localparam int unsigned STOPLAST = 16 * STOPBITS - 1;

`ifdef UART_PARAM_PARITY_EN
  localparam bit          PAR_ON  = (PARITY != 0);
  localparam bit          PAR_ODD = (PARITY == 1);
  localparam int unsigned WORDW   = DATABITS + 2;
`else
  localparam int unsigned WORDW   = DATABITS + 1;
  logic unusedParity;
  assign unusedParity = (PARITY != 0);
`endif

  typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP} txState_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rxState_t;

  logic [DIVW-1:0]     divCnt, divCntN;
  logic                tick16;

  txState_t            txState, txStateN;
  logic                txOutN, txRdyN;
  logic [DATABITS-1:0] txShift, txShiftN;
  logic [SUBW-1:0]     txSub, txSubN;
  logic [BITW-1:0]     txBit, txBitN;

  logic                rxMeta, rxSync;
  rxState_t            rxState, rxStateN;
  logic [DATABITS-1:0] rxShift, rxShiftN;
  logic [SUBW-1:0]     rxSub, rxSubN;
  logic [BITW-1:0]     rxBit, rxBitN;
  logic                push;

  logic [WORDW-1:0]    mem [RXFIFO_DEPTH];
  logic [WORDW-1:0]    pushWord, headN;
  logic [PTRW-1:0]     wrPtr, wrPtrN, rdPtr, rdPtrN;
  logic [CNTW-1:0]     rxCount, countN;
  logic                pop, full, wrEn, overrunN;

`ifdef UART_PARAM_PARITY_EN
  logic txPar, txParN, rxPerr, rxPerrN;
`endif

  // Free-running oversampling divider
  assign tick16  = (divCnt == DIVW'(DIV - 1));
  assign divCntN = tick16 ? '0 : divCnt + DIVW'(1);

  // Transmit sequencer; tx is updated on the tick that ends the previous bit
  always_comb begin
    txStateN = txState;
    txOutN   = tx;
    txRdyN   = txRdy;
    txShiftN = txShift;
    txSubN   = txSub;
    txBitN   = txBit;
`ifdef UART_PARAM_PARITY_EN
    txParN   = txPar;
`endif
    case (txState)
      TX_IDLE: if (txStb && txRdy) begin
        txShiftN = txData;
        txRdyN   = 1'b0;
        txSubN   = '0;
`ifdef UART_PARAM_PARITY_EN
        txParN   = PAR_ODD ? ~^txData : ^txData;
`endif
        if (tick16) begin
          txStateN = TX_START;
          txOutN   = 1'b0;
        end else begin
          txStateN = TX_WAIT;
        end
      end
      TX_WAIT: if (tick16) begin
        txStateN = TX_START;
        txOutN   = 1'b0;
      end
      TX_START: if (tick16) begin
        if (txSub == SUBW'(15)) begin
          txSubN   = '0;
          txBitN   = '0;
          txStateN = TX_DATA;
          txOutN   = txShift[0];
        end else begin
          txSubN = txSub + SUBW'(1);
        end
      end
      TX_DATA: if (tick16) begin
        if (txSub == SUBW'(15)) begin
          txSubN = '0;
          if (txBit == BITW'(DATABITS - 1)) begin
            txStateN = TX_STOP;
            txOutN   = 1'b1;
`ifdef UART_PARAM_PARITY_EN
            if (PAR_ON) begin
              txStateN = TX_PAR;
              txOutN   = txPar;
            end
`endif
          end else begin
            txBitN   = txBit + BITW'(1);
            txShiftN = txShift >> 1;
            txOutN   = txShift[1];
          end
        end else begin
          txSubN = txSub + SUBW'(1);
        end
      end
`ifdef UART_PARAM_PARITY_EN
      TX_PAR: if (tick16) begin
        if (txSub == SUBW'(15)) begin
          txSubN   = '0;
          txStateN = TX_STOP;
          txOutN   = 1'b1;
        end else begin
          txSubN = txSub + SUBW'(1);
        end
      end
`endif
      TX_STOP: if (tick16) begin
        if (txSub == SUBW'(STOPLAST)) begin
          txSubN   = '0;
          txStateN = TX_IDLE;
          txRdyN   = 1'b1;
        end else begin
          txSubN = txSub + SUBW'(1);
        end
      end
      default: ;
    endcase
  end

  // Receive sequencer; samples land on the synchronised line at bit centres
  always_comb begin
    rxStateN = rxState;
    rxShiftN = rxShift;
    rxSubN   = rxSub;
    rxBitN   = rxBit;
    push     = 1'b0;
`ifdef UART_PARAM_PARITY_EN
    rxPerrN  = rxPerr;
`endif
    case (rxState)
      RX_IDLE: if (tick16 && !rxSync) begin
        rxStateN = RX_START;
        rxSubN   = '0;
`ifdef UART_PARAM_PARITY_EN
        rxPerrN  = 1'b0;
`endif
      end
      RX_START: if (tick16) begin
        if (rxSub == SUBW'(7)) begin
          rxSubN   = '0;
          rxBitN   = '0;
          rxStateN = rxSync ? RX_IDLE : RX_DATA;
        end else begin
          rxSubN = rxSub + SUBW'(1);
        end
      end
      RX_DATA: if (tick16) begin
        if (rxSub == SUBW'(15)) begin
          rxSubN   = '0;
          rxShiftN = {rxSync, rxShift[DATABITS-1:1]};
          if (rxBit == BITW'(DATABITS - 1)) begin
            rxStateN = RX_STOP;
`ifdef UART_PARAM_PARITY_EN
            if (PAR_ON) rxStateN = RX_PAR;
`endif
          end else begin
            rxBitN = rxBit + BITW'(1);
          end
        end else begin
          rxSubN = rxSub + SUBW'(1);
        end
      end
`ifdef UART_PARAM_PARITY_EN
      RX_PAR: if (tick16) begin
        if (rxSub == SUBW'(15)) begin
          rxSubN   = '0;
          rxPerrN  = rxSync != (PAR_ODD ? ~^rxShift : ^rxShift);
          rxStateN = RX_STOP;
        end else begin
          rxSubN = rxSub + SUBW'(1);
        end
      end
`endif
      RX_STOP: if (tick16) begin
        if (rxSub == SUBW'(15)) begin
          rxSubN   = '0;
          push     = 1'b1;
          rxStateN = RX_IDLE;
        end else begin
          rxSubN = rxSub + SUBW'(1);
        end
      end
      default: ;
    endcase
  end

`ifdef UART_PARAM_PARITY_EN
  assign pushWord = {rxPerr, ~rxSync, rxShift};
`else
  assign pushWord = {~rxSync, rxShift};
`endif

  // FIFO bookkeeping; a push into a full FIFO survives only if a pop frees a slot
  always_comb begin
    pop      = rxAck && (rxCount != '0);
    full     = (rxCount == CNTW'(RXFIFO_DEPTH));
    wrEn     = push && (!full || pop);
    rdPtrN   = pop  ? rdPtr + PTRW'(1) : rdPtr;
    wrPtrN   = wrEn ? wrPtr + PTRW'(1) : wrPtr;
    countN   = rxCount + CNTW'(wrEn) - CNTW'(pop);
    headN    = (wrEn && (wrPtr == rdPtrN)) ? pushWord : mem[rdPtrN];
    if (countN == '0) headN = '0;
    overrunN = rxOverrun;
    if (rxAck) overrunN = 1'b0;
    else if (push && full) overrunN = 1'b1;
  end

  always_ff @(posedge SYSCLK) begin
    if (wrEn) mem[wrPtr] <= pushWord;
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      divCnt     <= '0;
      txState    <= TX_IDLE;
      tx         <= 1'b1;
      txRdy      <= 1'b1;
      txShift    <= '0;
      txSub      <= '0;
      txBit      <= '0;
      rxMeta     <= 1'b1;
      rxSync     <= 1'b1;
      rxState    <= RX_IDLE;
      rxShift    <= '0;
      rxSub      <= '0;
      rxBit      <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      rxCount    <= '0;
      rxRdy      <= 1'b0;
      rxData     <= '0;
      rxFrameErr <= 1'b0;
      rxOverrun  <= 1'b0;
    end else begin
      divCnt     <= divCntN;
      txState    <= txStateN;
      tx         <= txOutN;
      txRdy      <= txRdyN;
      txShift    <= txShiftN;
      txSub      <= txSubN;
      txBit      <= txBitN;
      rxMeta     <= rx;
      rxSync     <= rxMeta;
      rxState    <= rxStateN;
      rxShift    <= rxShiftN;
      rxSub      <= rxSubN;
      rxBit      <= rxBitN;
      wrPtr      <= wrPtrN;
      rdPtr      <= rdPtrN;
      rxCount    <= countN;
      rxRdy      <= (countN != '0);
      rxData     <= headN[DATABITS-1:0];
      rxFrameErr <= headN[DATABITS];
      rxOverrun  <= overrunN;
    end
  end

`ifdef UART_PARAM_PARITY_EN
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      txPar       <= 1'b0;
      rxPerr      <= 1'b0;
      rxParityErr <= 1'b0;
    end else begin
      txPar       <= txParN;
      rxPerr      <= rxPerrN;
      rxParityErr <= headN[DATABITS+1];
    end
  end
`else
  assign rxParityErr = 1'b0;
`endif

endmodule

// File: doc/uart_param.md
# uart_param

Parametrised 16x-oversampling UART: configurable data width, stop bits, optional parity, and a receive FIFO with per-entry error flags. It is the serial console and host link endpoint for the PDP-8 system. It sits between the bus-side strobe/ack interface and the `tx`/`rx` pins.

## Interface
Parameters:
- `XTAL`, 100_000_000: SYSCLK frequency in Hz.
- `BAUD`, 115200: line rate in baud.
- `DATABITS`, 8: data bits per frame; legal range 5..9.
- `STOPBITS`, 1: stop bits transmitted; legal values 1 or 2. The receiver always checks only the first stop bit.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even. It has effect only with `UART_PARAM_PARITY_EN`.
- `RXFIFO_DEPTH`, 4: receive FIFO entries; must be a power of 2, ≥2.

Ports:
- `SYSCLK`  in  1  system clock; the only clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `txData`  in  DATABITS  byte to send; sampled on an accepted `txStb`.
- `txStb`  in  1  one-cycle request to send.
- `txRdy`  out  1  high when a new `txStb` will be accepted.
- `tx`  out  1  serial output; idles high.
- `rx`  in  1  serial input; asynchronous to SYSCLK.
- `rxData`  out  DATABITS  data of the FIFO head entry.
- `rxRdy`  out  1  FIFO not empty.
- `rxAck`  in  1  one-cycle pop of the head entry.
- `rxFrameErr`  out  1  head entry's stop bit was sampled 0.
- `rxParityErr`  out  1  head entry failed the parity check; constant 0 without the macro.
- `rxOverrun`  out  1  sticky flag: a frame was dropped because the FIFO was full.

## Operation
- **Divider:** `DIV = XTAL/(BAUD*16)`; counter width `$clog2(DIV)`. It produces a `tick16` strobe one SYSCLK wide every DIV cycles and runs freely from reset.
- **RX input:** `rx` passes through a 2-flop synchroniser (reset to 1) before any use.
- **RX FSM:** IDLE → START → DATA → PARITY (only with the macro and PARITY≠0) → STOP → IDLE.
  - IDLE: enter START on the first `tick16` with synchronised rx=0; clear the sub-counter.
  - START: after 8 ticks, re-sample. If rx=1 it is a false start: return to IDLE with no push. Otherwise go to DATA.
  - DATA: sample every 16 ticks, LSB first, DATABITS samples.
  - PARITY: take one sample 16 ticks later and compare against the computed parity.
  - STOP: take one sample 16 ticks later, then push {parityErr, frameErr, data} to the FIFO and go to IDLE. The FSM does not wait for the line to return high; a 0 stop bit with rx held low re-enters START on the next tick.
- **FIFO:**
  - If the FIFO is full, the frame is dropped and `rxOverrun` is set.
  - `rxAck` pops the head when non-empty. `rxAck` on an empty FIFO is ignored.
  - `rxAck` also clears `rxOverrun`.
  - A push and a pop in the same cycle both take effect, including when the FIFO is full.
  - Pointers wrap modulo RXFIFO_DEPTH. Occupancy is tracked by a counter of width `$clog2(RXFIFO_DEPTH)+1`.
- **TX FSM:** IDLE → START → DATA → PARITY (optional) → STOP → IDLE.
  - `txStb` with `txRdy`=1 latches `txData` and leaves IDLE.
  - `txStb` while busy is ignored and the transmission in progress is unaffected.
  - Each bit lasts 16 ticks. STOP lasts 16·STOPBITS ticks. Data is sent LSB first.
- **Parity bit:** even = XOR of the data bits; odd = its inverse.

## Timing
- **Reset values:** `tx`=1, `txRdy`=1, `rxRdy`=0, `rxData`=0, all error flags 0. Both FSMs are in IDLE and the FIFO is empty.
- **Reset mid-frame:** a frame in progress is abandoned and `tx` goes to 1 immediately, since reset is asynchronous.
- **TX handshake:** `txRdy` falls the cycle after an accepted `txStb`. The start bit begins at the first `tick16` after acceptance. `txRdy` rises in the cycle after the last stop bit's final tick.
- **RX latency:** `rxRdy` rises one cycle after the `tick16` that samples the stop bit.
- **RX outputs:** `rxData` and the error flags are registered FIFO-head outputs. They are valid whenever `rxRdy`=1 and update the cycle after a pop.
- **Sample point:** nominal bit centre ±1 tick, plus 2 cycles of synchroniser delay.

## Configuration
- **`UART_PARAM_PARITY_EN` defined:** the PARITY parameter is honoured, the parity bit is generated and checked, and `rxParityErr` is live.
- **Macro undefined:** no parity logic is built, frames are always DATA+STOP, the PARITY parameter is ignored, and `rxParityErr` is tied to 0.

## Test plan
All scenarios use XTAL=16_000_000 and BAUD=1_000_000, so DIV=1 and one bit is 16 cycles.
1. TX of 0xA5 with 8N1 → `tx` holds 0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1. `txRdy` is low for 160 cycles. A second `txStb` mid-frame is ignored.
2. Loopback `tx`→`rx` of 0x3C, then 0xFF → `rxRdy`=1 with `rxData`=0x3C and all error flags 0. After `rxAck`, `rxData`=0xFF. A second `rxAck` leaves `rxRdy`=0.
3. Pulse `rx` low for 4 cycles only → no push; `rxRdy` stays 0.
4. Frame 0x55 with the stop bit driven 0 → entry 0x55 with `rxFrameErr`=1. The next clean frame has `rxFrameErr`=0.
5. Five frames 0x01..0x05 with no ack and RXFIFO_DEPTH=4 → `rxOverrun`=1 and pops return 0x01..0x04. `rxOverrun` clears on the first `rxAck`.
6. Macro on, PARITY=2 → TX of 0x07 emits parity bit 1. An injected frame 0x07 with parity bit 0 gives `rxParityErr`=1. Asserting RESET mid-frame forces `tx`=1 and `txRdy`=1 within the same cycle.
